// File: rtl/fetch_unit.sv
// Instruction fetch requester: owns the fetch PC, keeps up to FIFO_DEPTH reads in flight, and buffers words for decode.
// Optional macro FETCH_MISALIGN_TRAP_EN turns a misaligned redirect into a flagged NOP entry and halts fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [31:0] ImemAddr,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  output logic        IfValid,
  input  logic        IfReady,
  output logic [31:0] IfPC,
  output logic [31:0] IfInstruction,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        IfMisaligned
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic [31:0]           pc_mem    [FIFO_DEPTH];
  logic [31:0]           instr_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] filled;
  logic [PW-1:0]         head, tail, fill_ptr;
  logic [CW-1:0]         alloc_cnt, unfilled_cnt, drop_cnt;
  logic [31:0]           fetch_pc;
  logic                  halted;

  logic        accept, pop, rsp_drop, rsp_fill, redirect_trap;
  logic [CW:0] inflight_sum;
  logic [31:0] redirect_pc_al;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic [FIFO_DEPTH-1:0] mis;
  assign redirect_trap = Redirect && (RedirectPC[1:0] != 2'b00);
  assign IfMisaligned  = IfValid && mis[head];
`else
  assign redirect_trap = 1'b0;
`endif

  assign redirect_pc_al = RedirectPC & ~32'h0000_0003;

  // Registered counts only: dropped responses still occupy memory-side slots.
  assign inflight_sum = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
  assign ImemReqValid = !rst && !Redirect && !halted && (inflight_sum < DEPTH_L);
  assign ImemAddr     = fetch_pc;
  assign accept       = ImemReqValid && ImemReqReady;

  assign IfValid       = filled[head];
  assign IfPC          = IfValid ? pc_mem[head]    : 32'h0;
  assign IfInstruction = IfValid ? instr_mem[head] : 32'h0;
  assign pop           = IfValid && IfReady;

  assign rsp_drop = ImemRspValid && (drop_cnt != '0);
  assign rsp_fill = ImemRspValid && (drop_cnt == '0) && (unfilled_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      fill_ptr     <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
      drop_cnt     <= '0;
      filled       <= '0;
      fetch_pc     <= RESET_PC;
      halted       <= 1'b0;
    end else if (Redirect) begin
      head         <= '0;
      tail         <= '0;
      fill_ptr     <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
      // Every unfilled request still returns a word; a same-cycle response is one of them.
      drop_cnt     <= drop_cnt + unfilled_cnt - CW'(rsp_drop || rsp_fill);
      filled       <= '0;
      fetch_pc     <= redirect_pc_al;
      halted       <= redirect_trap;
      if (redirect_trap) begin
        filled[0] <= 1'b1;
        tail      <= PW'(1);
        fill_ptr  <= PW'(1);
        alloc_cnt <= CW'(1);
      end
    end else begin
      if (accept) begin
        filled[tail] <= 1'b0;
        tail         <= tail + PW'(1);
        fetch_pc     <= fetch_pc + 32'd4;
      end
      if (rsp_drop)
        drop_cnt <= drop_cnt - CW'(1);
      if (rsp_fill) begin
        filled[fill_ptr] <= 1'b1;
        fill_ptr         <= fill_ptr + PW'(1);
      end
      if (pop) begin
        filled[head] <= 1'b0;
        head         <= head + PW'(1);
      end
      alloc_cnt    <= alloc_cnt + CW'(accept) - CW'(pop);
      unfilled_cnt <= unfilled_cnt + CW'(accept) - CW'(rsp_fill);
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mis <= '0;
    end else if (Redirect) begin
      mis <= '0;
      if (redirect_trap)
        mis[0] <= 1'b1;
    end else if (accept) begin
      mis[tail] <= 1'b0;
    end
  end
`endif

  // Entry payload carries no reset; validity is tracked by filled.
  always_ff @(posedge clk) begin
    if (redirect_trap) begin
      pc_mem[0]    <= RedirectPC;
      instr_mem[0] <= 32'h0000_0013;
    end else if (!Redirect) begin
      if (accept)
        pc_mem[tail] <= fetch_pc;
      if (rsp_fill)
        instr_mem[fill_ptr] <= ImemRspData;
    end
  end

  // A response with nothing outstanding means the memory broke the protocol.
  always_ff @(posedge clk) begin
    if (!rst && !Redirect)
      assert (!(ImemRspValid && (drop_cnt == '0) && (unfilled_cnt == '0)));
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable in-order memory model.
// Define FETCH_MISALIGN_TRAP_EN for both files to exercise the misaligned-redirect trap.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ImemReqValid;
  logic        ImemReqReady = 1'b0;
  logic [31:0] ImemAddr;
  logic        ImemRspValid = 1'b0;
  logic [31:0] ImemRspData  = 32'h0;
  logic        IfValid;
  logic        IfReady = 1'b0;
  logic [31:0] IfPC;
  logic [31:0] IfInstruction;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        if_misaligned;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .ImemReqValid(ImemReqValid), .ImemReqReady(ImemReqReady), .ImemAddr(ImemAddr),
    .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
    .IfValid(IfValid), .IfReady(IfReady), .IfPC(IfPC), .IfInstruction(IfInstruction),
    .Redirect(Redirect), .RedirectPC(RedirectPC)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .IfMisaligned(if_misaligned)
`endif
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend[$];
  logic [31:0] acc_addr[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          ready_toggle = 1'b0;
  logic        n_rst = 1'b1, n_redirect = 1'b0, n_ifready = 1'b0;
  logic [31:0] n_rpc = 32'h0;
  int          stall_viol = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  // One clock cycle with the n_* settings; on return outputs describe this cycle.
  task automatic step();
    pend_t e;
    @(negedge clk);
    rst          = n_rst;
    Redirect     = n_redirect;
    RedirectPC   = n_rpc;
    IfReady      = n_ifready;
    ImemReqReady = ready_toggle ? cyc[0] : 1'b1;
    ImemRspValid = 1'b0;
    ImemRspData  = 32'h0;
    if (!n_rst && pend.size() > 0 && pend[0].due <= cyc) begin
      ImemRspValid = 1'b1;
      ImemRspData  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    #1;
    if (!rst) begin
      if (prev_stall && !Redirect && !(ImemReqValid && ImemAddr == prev_addr))
        stall_viol++;
      prev_stall = ImemReqValid && !ImemReqReady;
      prev_addr  = ImemAddr;
      if (ImemReqValid && ImemReqReady) begin
        e.addr = ImemAddr;
        e.due  = cyc + lat;
        pend.push_back(e);
        acc_addr.push_back(ImemAddr);
      end
      if (IfValid && IfReady) begin
        got_pc.push_back(IfPC);
        got_ins.push_back(IfInstruction);
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    n_rst = 1'b1; n_redirect = 1'b0; n_ifready = 1'b0; ready_toggle = 1'b0;
    step();
    step();
    n_rst = 1'b0;
    pend.delete(); acc_addr.delete(); got_pc.delete(); got_ins.delete();
    stall_viol = 0; prev_stall = 1'b0; cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ImemReqValid !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", ImemReqValid); end
    checks++; if (IfValid !== 1'b0) begin failures++; $display("FAIL reset_ifvalid: got %b expected 0", IfValid); end
    checks++; if (IfPC !== 32'h0) begin failures++; $display("FAIL reset_ifpc: got %h expected 0", IfPC); end
    checks++; if (IfInstruction !== 32'h0) begin failures++; $display("FAIL reset_ifinstr: got %h expected 0", IfInstruction); end
    lat = 3; n_ifready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    do_reset();
    n_ifready = 1'b1; lat = 1;
    step();
    checks++; if (ImemReqValid !== 1'b1 || ImemAddr !== 32'h0) begin failures++; $display("FAIL midreset_restart: got v=%b a=%h expected v=1 a=0", ImemReqValid, ImemAddr); end
    checks++; if (IfValid !== 1'b0) begin failures++; $display("FAIL midreset_ifvalid: got %b expected 0", IfValid); end
  endtask

  task automatic test_stream();
    int first_valid = -1;
    int seq_err = 0;
    do_reset();
    lat = 1; n_ifready = 1'b1;
    for (int s = 0; s < 12; s++) begin
      step();
      if (IfValid && first_valid < 0) first_valid = s;
    end
    checks++; if (acc_addr.size() < 3 || acc_addr[0] !== 32'h0 || acc_addr[1] !== 32'h4 || acc_addr[2] !== 32'h8) begin failures++; $display("FAIL stream_addrs: got %h %h %h expected 0 4 8", acc_addr[0], acc_addr[1], acc_addr[2]); end
    checks++; if (first_valid !== 2) begin failures++; $display("FAIL stream_latency: got %0d expected 2", first_valid); end
    checks++; if (got_pc.size() !== 10) begin failures++; $display("FAIL stream_rate: got %0d expected 10", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++)
      if (got_pc[i] !== 32'(4*i) || got_ins[i] !== mem_word(32'(4*i))) seq_err++;
    checks++; if (seq_err !== 0) begin failures++; $display("FAIL stream_order: got %0d bad entries expected 0", seq_err); end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 1; n_ifready = 1'b0;
    for (int s = 0; s < 10; s++) step();
    checks++; if (acc_addr.size() !== 4) begin failures++; $display("FAIL bp_accepts: got %0d expected 4", acc_addr.size()); end
    checks++; if (ImemReqValid !== 1'b0) begin failures++; $display("FAIL bp_reqvalid: got %b expected 0", ImemReqValid); end
    checks++; if (IfValid !== 1'b1 || IfPC !== 32'h0 || IfInstruction !== mem_word(32'h0)) begin failures++; $display("FAIL bp_hold: got v=%b pc=%h ins=%h expected v=1 pc=0 ins=%h", IfValid, IfPC, IfInstruction, mem_word(32'h0)); end
    n_ifready = 1'b1;
    for (int s = 0; s < 8; s++) step();
    checks++; if (got_pc.size() < 4 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4 || got_pc[2] !== 32'h8 || got_pc[3] !== 32'hC) begin failures++; $display("FAIL bp_drain: got %h %h %h %h expected 0 4 8 c", got_pc[0], got_pc[1], got_pc[2], got_pc[3]); end
    checks++; if (acc_addr.size() < 5 || acc_addr[4] !== 32'h10) begin failures++; $display("FAIL bp_resume: got %h expected 10", acc_addr[4]); end
  endtask

  task automatic test_latency_stall();
    int seq_err = 0;
    do_reset();
    lat = 3; ready_toggle = 1'b1; n_ifready = 1'b1;
    for (int i = 0; i < 400 && got_pc.size() < 32; i++) step();
    ready_toggle = 1'b0;
    checks++; if (got_pc.size() < 32) begin failures++; $display("FAIL lat_timeout: got %0d instrs expected 32", got_pc.size()); end
    for (int i = 0; i < 32; i++) begin
      if (got_pc[i] !== 32'(4*i) || got_ins[i] !== mem_word(32'(4*i))) seq_err++;
      if (acc_addr[i] !== 32'(4*i)) seq_err++;
    end
    checks++; if (seq_err !== 0) begin failures++; $display("FAIL lat_sequence: got %0d errors expected 0", seq_err); end
    checks++; if (stall_viol !== 0) begin failures++; $display("FAIL lat_addr_stable: got %0d violations expected 0", stall_viol); end
  endtask

  task automatic test_redirect_flush();
    int seq_err = 0;
    do_reset();
    lat = 4; n_ifready = 1'b1;
    for (int s = 0; s < 4; s++) step();
    n_redirect = 1'b1; n_rpc = 32'h100;
    step();
    checks++; if (ImemReqValid !== 1'b0) begin failures++; $display("FAIL rd_noreq: got %b expected 0", ImemReqValid); end
    n_redirect = 1'b0;
    step();
    checks++; if (ImemReqValid !== 1'b1 || ImemAddr !== 32'h100) begin failures++; $display("FAIL rd_first_req: got v=%b a=%h expected v=1 a=100", ImemReqValid, ImemAddr); end
    checks++; if (IfValid !== 1'b0) begin failures++; $display("FAIL rd_ifvalid: got %b expected 0", IfValid); end
    for (int s = 0; s < 20; s++) step();
    checks++; if (got_pc.size() < 4 || got_pc[0] !== 32'h100 || got_ins[0] !== mem_word(32'h100)) begin failures++; $display("FAIL rd_first_instr: got pc=%h ins=%h expected pc=100 ins=%h", got_pc[0], got_ins[0], mem_word(32'h100)); end
    for (int i = 0; i < got_pc.size(); i++)
      if (got_pc[i] !== 32'h100 + 32'(4*i) || got_ins[i] !== mem_word(32'h100 + 32'(4*i))) seq_err++;
    checks++; if (seq_err !== 0) begin failures++; $display("FAIL rd_stream: got %0d bad entries expected 0", seq_err); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    lat = 1; n_ifready = 1'b1;
    for (int s = 0; s < 3; s++) step();
    got_pc.delete(); got_ins.delete(); acc_addr.delete();
    n_redirect = 1'b1; n_rpc = 32'hFFFF_FFF8;
    step();
    checks++; if (got_pc.size() !== 1 || got_pc[0] !== 32'h4) begin failures++; $display("FAIL wrap_redirect_xfer: got n=%0d pc=%h expected n=1 pc=4", got_pc.size(), got_pc[0]); end
    n_redirect = 1'b0;
    got_pc.delete(); got_ins.delete();
    for (int s = 0; s < 5; s++) step();
    checks++; if (acc_addr.size() < 3 || acc_addr[0] !== 32'hFFFF_FFF8 || acc_addr[1] !== 32'hFFFF_FFFC || acc_addr[2] !== 32'h0) begin failures++; $display("FAIL wrap_addrs: got %h %h %h expected fffffff8 fffffffc 0", acc_addr[0], acc_addr[1], acc_addr[2]); end
    checks++; if (got_pc.size() !== 3 || got_pc[0] !== 32'hFFFF_FFF8 || got_pc[2] !== 32'h0 || got_ins[2] !== mem_word(32'h0)) begin failures++; $display("FAIL wrap_instrs: got n=%0d pc0=%h pc2=%h expected n=3 pc0=fffffff8 pc2=0", got_pc.size(), got_pc[0], got_pc[2]); end
  endtask

  task automatic test_misaligned();
    do_reset();
    lat = 1; n_ifready = 1'b0;
    step(); step();
    acc_addr.delete();
    n_redirect = 1'b1; n_rpc = 32'h102;
    step();
    n_redirect = 1'b0;
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (IfValid !== 1'b1 || IfPC !== 32'h102 || IfInstruction !== 32'h13 || if_misaligned !== 1'b1) begin failures++; $display("FAIL mis_entry: got v=%b pc=%h ins=%h m=%b expected v=1 pc=102 ins=13 m=1", IfValid, IfPC, IfInstruction, if_misaligned); end
    for (int s = 0; s < 3; s++) step();
    checks++; if (acc_addr.size() !== 0 || ImemReqValid !== 1'b0) begin failures++; $display("FAIL mis_halt: got %0d accepts v=%b expected 0 accepts v=0", acc_addr.size(), ImemReqValid); end
    n_ifready = 1'b1;
    step();
    got_pc.delete(); got_ins.delete();
    step();
    checks++; if (IfValid !== 1'b0 || ImemReqValid !== 1'b0) begin failures++; $display("FAIL mis_after_pop: got v=%b req=%b expected 0 0", IfValid, ImemReqValid); end
    n_redirect = 1'b1; n_rpc = 32'h200;
    step();
    n_redirect = 1'b0;
    step();
    checks++; if (ImemReqValid !== 1'b1 || ImemAddr !== 32'h200) begin failures++; $display("FAIL mis_restart: got v=%b a=%h expected v=1 a=200", ImemReqValid, ImemAddr); end
    for (int s = 0; s < 4; s++) step();
    checks++; if (got_pc.size() < 1 || got_pc[0] !== 32'h200 || got_ins[0] !== mem_word(32'h200) || if_misaligned !== 1'b0) begin failures++; $display("FAIL mis_resume_instr: got pc=%h ins=%h m=%b expected pc=200 ins=%h m=0", got_pc[0], got_ins[0], if_misaligned, mem_word(32'h200)); end
`else
    checks++; if (ImemReqValid !== 1'b1 || ImemAddr !== 32'h100) begin failures++; $display("FAIL mis_forced_align: got v=%b a=%h expected v=1 a=100", ImemReqValid, ImemAddr); end
    checks++; if (IfValid !== 1'b0) begin failures++; $display("FAIL mis_ifvalid: got %b expected 0", IfValid); end
`endif
  endtask

  task automatic test_back_to_back();
    int seq_err = 0;
    do_reset();
    lat = 3; n_ifready = 1'b1;
    for (int s = 0; s < 3; s++) step();
    n_redirect = 1'b1; n_rpc = 32'h200;
    step();
    n_rpc = 32'h300;
    step();
    checks++; if (ImemReqValid !== 1'b0) begin failures++; $display("FAIL b2b_noreq: got %b expected 0", ImemReqValid); end
    n_redirect = 1'b0;
    got_pc.delete(); got_ins.delete();
    step();
    checks++; if (ImemReqValid !== 1'b1 || ImemAddr !== 32'h300) begin failures++; $display("FAIL b2b_first_req: got v=%b a=%h expected v=1 a=300", ImemReqValid, ImemAddr); end
    for (int s = 0; s < 15; s++) step();
    checks++; if (got_pc.size() < 4 || got_pc[0] !== 32'h300 || got_ins[0] !== mem_word(32'h300)) begin failures++; $display("FAIL b2b_first_instr: got pc=%h ins=%h expected pc=300 ins=%h", got_pc[0], got_ins[0], mem_word(32'h300)); end
    for (int i = 0; i < got_pc.size(); i++)
      if (got_pc[i] !== 32'h300 + 32'(4*i) || got_ins[i] !== mem_word(32'h300 + 32'(4*i))) seq_err++;
    checks++; if (seq_err !== 0) begin failures++; $display("FAIL b2b_stream: got %0d bad entries expected 0", seq_err); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_latency_stall();
    test_redirect_flush();
    test_pc_wrap();
    test_misaligned();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
